// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding and
// the condition-AL NOP also used as the fetch-stage default instruction.
package inst_fetch_ctrl_pkg;

  localparam int          FETCH_ADDR_W = 32;
  localparam logic [31:0] FETCH_NOP    = 32'hE000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2,
    ST_VALID = 2'd3
  } fetch_state_t;

  // The PC register may only move when an instruction leaves or a branch redirects.
  function automatic logic freeze_for(input fetch_state_t s, input logic branch_taken,
                                      input logic pipe_stall);
    logic f;
    f = 1'b1;
    case (s)
      ST_IDLE:  f = 1'b1;
      ST_WAIT:  f = ~branch_taken;
      ST_DROP:  f = ~branch_taken;
      ST_VALID: f = pipe_stall & ~branch_taken;
      default:  f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the SRAM read handshake, freezes the
// fetch-stage PC until an instruction is delivered, and drops stale reads.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] NOP_INST = ADDR_W'(FETCH_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              pipe_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] inst,
  output logic              inst_valid,
  output logic              fetch_freeze,
  output fetch_state_t      dbg_state
);

  // Memory handshake: mem_req acts as valid and mem_ack as the completing
  // ready; mem_addr stays stable from the rise of mem_req up to and including
  // the ack cycle, and a new address may follow immediately with mem_req held.
  // Acks arriving while no request is outstanding are ignored.

  fetch_state_t      state;
  logic [ADDR_W-1:0] next_addr;

  assign next_addr    = branch_taken ? branch_addr : fetch_pc + ADDR_W'(4);
  assign fetch_freeze = freeze_for(state, branch_taken, pipe_stall);
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_WAIT;
          mem_req  <= 1'b1;
          mem_addr <= fetch_pc;
        end
        ST_WAIT: begin
          if (mem_ack) begin
            if (branch_taken) begin
              mem_addr <= branch_addr;
            end else begin
              inst       <= mem_rdata;
              inst_valid <= 1'b1;
              mem_req    <= 1'b0;
              state      <= ST_VALID;
            end
          end else if (branch_taken) begin
            // Read still in flight for the old PC; hold its address until it acks.
            state <= ST_DROP;
          end
        end
        ST_DROP: begin
          // By now the PC register already holds the latest redirect target.
          if (mem_ack) begin
            mem_addr <= branch_taken ? branch_addr : fetch_pc;
            state    <= ST_WAIT;
          end
        end
        ST_VALID: begin
          if (branch_taken || !pipe_stall) begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            mem_req    <= 1'b1;
            mem_addr   <= next_addr;
            state      <= ST_WAIT;
          end
        end
        default: begin
          state      <= ST_IDLE;
          mem_req    <= 1'b0;
          inst       <= NOP_INST;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
